fft_input_loader: RTL and testbench
===================================

Name: fft_input_loader

Overview:
- Front-end formatter for the CORDIC-based fixed-point FFT pipeline.
- Accepts a serial stream of complex samples, one per cycle at most.
- Buffers each N-point frame in a ping-pong RAM pair.
- Emits the frame as butterfly pairs (x[k], x[k+N/2]) on the dual-sample a/b interface used by every stage_* module.
- Performs the write-side counterpart of the stage output buffers: serial in, paired out.

Parameters:
- N_POINTS, 1024, FFT frame length; power of two, at least 4.
- DATA_W, 32, width of the two's-complement fixed-point real and imaginary parts.
- ADDR_W, 10, log2(N_POINTS).

Ports:
- i_clk  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-low reset
- i_valid_in  in  1  sample strobe; no backpressure, the sample is accepted whenever high
- i_data_real  in  DATA_W  sample real part
- i_data_imag  in  DATA_W  sample imaginary part
- o_valid_out  out  1  pair valid
- o_sof  out  1  high with the first pair (k=0) of each frame
- o_data_a_real  out  DATA_W  x[k] real
- o_data_a_imag  out  DATA_W  x[k] imaginary
- o_data_b_real  out  DATA_W  x[k+N/2] real
- o_data_b_imag  out  DATA_W  x[k+N/2] imaginary

Behaviour:
- Reset: all outputs 0. wr_cnt=0, wr_bank=0, rd_cnt=0, read FSM IDLE, both banks marked empty. Reset is asynchronous and may arrive at any time; partially written or partially read frames are discarded with no further output.
- Storage: two banks, each with a real and an imaginary dual_port_ram of N_POINTS words.
  - The write bank uses port A for writes.
  - The read bank reads port A at address k and port B at address k+N/2 in the same cycle.
  - A bank is never written and read simultaneously.
- Write side:
  - On each edge with i_valid_in=1, write the sample to wr_bank[wr_cnt] and increment wr_cnt.
  - Gaps in i_valid_in hold wr_cnt.
  - When wr_cnt=N-1 and i_valid_in=1: wr_cnt wraps to 0, wr_bank toggles, and a one-cycle frame_done pulse is issued for the completed bank.
- Read FSM:
  - IDLE: on frame_done, latch rd_bank = completed bank, set rd_cnt=0, go to READ.
  - READ: issue one address pair per cycle (rd_cnt, rd_cnt+N/2), rd_cnt++. After issuing rd_cnt=N/2-1, return to IDLE.
  - Reading takes N/2 cycles and writing the next frame takes at least N cycles, so frame_done never arrives while in READ. If it does (only via a design error), set an internal sticky error bit that the bench checks; no port is needed.
- Pipeline:
  - The read address is registered into the RAM, the RAM read has 1-cycle latency, and the output is registered.
  - A 3-stage valid/sof shift register runs alongside the data path.
  - The first o_valid_out is asserted on the 3rd rising edge after the edge that accepted sample N-1.
  - o_valid_out is then high for exactly N/2 consecutive cycles.
  - o_sof is high only with k=0.
- Output data:
  - Samples pass bit-exact; no scaling, rounding or sign manipulation.
  - Output registers hold their last value when o_valid_out=0.
- Back-to-back frames with continuous i_valid_in produce N/2-cycle output bursts separated by N/2 idle cycles, with no data loss.

Test Plan:
1. Single frame, continuous valid, real=n, imag=-n for n=0..1023. Required: first valid on the 3rd edge after sample 1023; pair k carries a=(k,-k), b=(k+512,-(k+512)); 512 pairs; o_sof only at k=0.
2. Three back-to-back frames with offsets 0, 4096 and 8192 added to n. Required: each burst carries only its own frame, bank alternates, no pair lost or duplicated, 512 idle cycles between bursts.
3. i_valid_in randomly deasserted (about 50% duty) during a frame. Required: output identical to scenario 1; burst starts 3 edges after the 1024th accepted sample.
4. Assert i_reset at sample 500, then send a full frame. Required: no output for the partial frame; the next frame's first pair is a=(0,0), b=(512,-512) with correct timing.
5. Assert i_reset at pair k=100 of a burst. Required: o_valid_out falls to 0 asynchronously, outputs read 0, no remaining pairs appear; the following frame is output correctly.
6. Signed extremes: x[0]=0x80000000+j0x7FFFFFFF, x[512]=0x7FFFFFFF+j0x80000000. Required: first pair reproduces both values bit-exact.

Source files
------------

// File: rtl/fft_input_loader.sv
`timescale 1ns/1ps
// dual_port_ram
//   N-word RAM with two ports and a 1-cycle read latency.
//   Port A: write (we_a) or read at addr_a. Port B: read only at addr_b.
//   A read of a word being written in the same cycle returns the old word.
//   The loader never reads and writes one bank at the same time.
module dual_port_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] d_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] q_b
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we_a) mem[addr_a] <= d_a;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end
endmodule

// fft_input_loader
//   Serial-in, butterfly-pair-out front end of the FFT pipeline.
//   Samples are written into a ping-pong bank pair. Once a bank holds a
//   complete frame, it is read out as pairs (x[k], x[k+N/2]), k = 0..N/2-1.
//   Ports:
//     i_clk, i_reset (async, active low)
//     i_valid_in, i_data_real, i_data_imag : sample input, no backpressure
//     o_valid_out, o_sof                   : pair valid, first pair of frame
//     o_data_a_*, o_data_b_*               : x[k] and x[k+N/2]
//   Latency: the first pair is valid on the 3rd rising edge after the edge
//   that accepted the last sample of a frame.
module fft_input_loader #(
  parameter int N_POINTS = 1024,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid_in,
  input  logic [DATA_W-1:0] i_data_real,
  input  logic [DATA_W-1:0] i_data_imag,
  output logic              o_valid_out,
  output logic              o_sof,
  output logic [DATA_W-1:0] o_data_a_real,
  output logic [DATA_W-1:0] o_data_a_imag,
  output logic [DATA_W-1:0] o_data_b_real,
  output logic [DATA_W-1:0] o_data_b_imag
);
  localparam int HALF   = N_POINTS / 2;
  localparam int RW     = ADDR_W - 1;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic {IDLE, READ} state_t;

  // ---------------- write side ----------------
  logic [ADDR_W-1:0] wr_cnt;
  logic              wr_bank;
  logic              frame_done;
  logic              done_bank;
  logic              wr_last;

  assign wr_last = (wr_cnt == ADDR_W'(N_POINTS - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
      done_bank  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (i_valid_in) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + ADDR_W'(1);
        if (wr_last) begin
          wr_bank    <= ~wr_bank;
          frame_done <= 1'b1;
          done_bank  <= wr_bank;
        end
      end
    end
  end

  // ---------------- read FSM ----------------
  state_t          state, state_nx;
  logic [RW-1:0]   rd_cnt;
  logic            rd_bank;
  logic            rd_last;
  logic [1:0]      bank_full;
  logic            err_sticky;

  assign rd_last = (rd_cnt == RW'(HALF - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (frame_done) state_nx = READ;
      READ: if (rd_last)    state_nx = IDLE;
    endcase
  end

  // vld_pipe[0]/sof_pipe[0] track the address issue stage, [1] the RAM
  // output stage, [2] the output register.
  logic [STAGES:0] vld_pipe, sof_pipe;
  logic            bank_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      rd_bank    <= 1'b0;
      bank_full  <= '0;
      err_sticky <= 1'b0;
      vld_pipe   <= '0;
      sof_pipe   <= '0;
      bank_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_cnt   <= (state == IDLE) ? '0 : rd_cnt + RW'(1);
      if (state == IDLE && frame_done) rd_bank <= done_bank;
      vld_pipe <= {vld_pipe[STAGES-1:0], state_nx == READ};
      sof_pipe <= {sof_pipe[STAGES-1:0], state == IDLE && frame_done};
      bank_q   <= rd_bank;
      for (int b = 0; b < 2; b++) begin
        if (frame_done && done_bank == 1'(b))
          bank_full[b] <= 1'b1;
        else if (state == READ && rd_last && rd_bank == 1'(b))
          bank_full[b] <= 1'b0;
      end
      // A completed frame must find the reader idle and its bank drained.
      if (frame_done && (state == READ || bank_full[done_bank]))
        err_sticky <= 1'b1;
    end
  end

  // ---------------- bank pair ----------------
  cplx_t                         wr_smp;
  cplx_t [1:0]                   bank_qa, bank_qb;
  logic  [ADDR_W-1:0]            rd_addr_lo, rd_addr_hi;

  assign wr_smp     = '{re: i_data_real, im: i_data_imag};
  assign rd_addr_lo = {1'b0, rd_cnt};
  assign rd_addr_hi = {1'b1, rd_cnt};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic              is_wr;
    logic [ADDR_W-1:0] addr_a;
    assign is_wr  = (wr_bank == 1'(b));
    assign addr_a = is_wr ? wr_cnt : rd_addr_lo;

    dual_port_ram #(.DEPTH(N_POINTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_re (
      .i_clk(i_clk), .we_a(i_valid_in & is_wr), .addr_a(addr_a), .d_a(wr_smp.re),
      .q_a(bank_qa[b].re), .addr_b(rd_addr_hi), .q_b(bank_qb[b].re));

    dual_port_ram #(.DEPTH(N_POINTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_im (
      .i_clk(i_clk), .we_a(i_valid_in & is_wr), .addr_a(addr_a), .d_a(wr_smp.im),
      .q_a(bank_qa[b].im), .addr_b(rd_addr_hi), .q_b(bank_qb[b].im));
  end

  // ---------------- output register ----------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_data_a_real <= '0;
      o_data_a_imag <= '0;
      o_data_b_real <= '0;
      o_data_b_imag <= '0;
    end else if (vld_pipe[1]) begin
      o_data_a_real <= bank_qa[bank_q].re;
      o_data_a_imag <= bank_qa[bank_q].im;
      o_data_b_real <= bank_qb[bank_q].re;
      o_data_b_imag <= bank_qb[bank_q].im;
    end
  end

  assign o_valid_out = vld_pipe[STAGES];
  assign o_sof       = sof_pipe[STAGES];
endmodule

// File: tb/tb_fft_input_loader.sv
`timescale 1ns/1ps
module tb_fft_input_loader;
  localparam int N = 1024, DW = 32, AW = 10, H = N / 2;

  logic          i_clk = 1'b0, i_reset = 1'b0, i_valid_in = 1'b0;
  logic [DW-1:0] i_data_real = '0, i_data_imag = '0;
  logic          o_valid_out, o_sof;
  logic [DW-1:0] o_data_a_real, o_data_a_imag, o_data_b_real, o_data_b_imag;

  always #5 i_clk = ~i_clk;

  fft_input_loader #(.N_POINTS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid_in(i_valid_in),
    .i_data_real(i_data_real), .i_data_imag(i_data_imag),
    .o_valid_out(o_valid_out), .o_sof(o_sof),
    .o_data_a_real(o_data_a_real), .o_data_a_imag(o_data_a_imag),
    .o_data_b_real(o_data_b_real), .o_data_b_imag(o_data_b_imag));

  int checks = 0, errors = 0;

  task automatic check(input string nm, input logic [129:0] got, input logic [129:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Accepted samples collect into a frame; a complete frame schedules its
  // N/2 pairs on consecutive edges starting 3 edges after completion.
  typedef struct {
    int          due;
    bit          sof;
    logic [31:0] ar, ai, br, bi;
  } pair_t;

  pair_t        exp_q[$];
  logic [31:0]  fr_re[$], fr_im[$];
  int           edge_n = 0, last_done_edge = 0;
  logic [127:0] last_data = '0;
  logic [129:0] expv;
  pair_t        p;

  logic [31:0]  cap_ar[$], cap_ai[$], cap_br[$], cap_bi[$];
  bit           cap_sof[$];
  int           sof_edge[$];

  initial forever begin
    @(posedge i_clk);
    edge_n++;
    if (!i_reset) begin
      fr_re.delete(); fr_im.delete();
    end else if (i_valid_in) begin
      fr_re.push_back(i_data_real);
      fr_im.push_back(i_data_imag);
      if (fr_re.size() == N) begin
        for (int k = 0; k < H; k++)
          exp_q.push_back('{edge_n + 3 + k, k == 0, fr_re[k], fr_im[k], fr_re[k+H], fr_im[k+H]});
        last_done_edge = edge_n;
        fr_re.delete(); fr_im.delete();
      end
    end
    @(negedge i_clk);
    if (!i_reset) begin
      exp_q.delete(); fr_re.delete(); fr_im.delete();
      last_data = '0;
      expv      = '0;
    end else if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      p         = exp_q.pop_front();
      last_data = {p.ar, p.ai, p.br, p.bi};
      expv      = {1'b1, p.sof, last_data};
    end else begin
      expv = {2'b00, last_data};
    end
    check("out", {o_valid_out, o_sof, o_data_a_real, o_data_a_imag, o_data_b_real, o_data_b_imag}, expv);
    if (o_valid_out) begin
      cap_ar.push_back(o_data_a_real); cap_ai.push_back(o_data_a_imag);
      cap_br.push_back(o_data_b_real); cap_bi.push_back(o_data_b_imag);
      cap_sof.push_back(o_sof);
      if (o_sof) sof_edge.push_back(edge_n);
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    int k, ar, ai, br, bi;
    bit sof;
  } vec_t;
  vec_t tbl[5];

  task automatic drive(input logic v, input logic [31:0] re, input logic [31:0] im);
    @(posedge i_clk); #2;
    i_valid_in = v; i_data_real = re; i_data_imag = im;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, $urandom, $urandom);
  endtask

  task automatic send_ramp(input int off, input int gap_pct, input int count);
    for (int n = 0; n < count; n++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
      drive(1'b1, 32'(n + off), 32'(-(n + off)));
    end
  endtask

  task automatic drain(input string nm);
    idle(1);
    for (int i = 0; i < 4 * N; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge i_clk); #1;
    end
    check({nm, "_drained"}, exp_q.size() == 0, 1);
    idle(4);
  endtask

  task automatic clear_cap();
    cap_ar.delete(); cap_ai.delete(); cap_br.delete(); cap_bi.delete();
    cap_sof.delete(); sof_edge.delete();
  endtask

  task automatic check_table(input string nm);
    for (int i = 0; i < 5; i++) begin
      int k = tbl[i].k;
      if (k < cap_ar.size())
        check($sformatf("%s_k%0d", nm, k),
              {cap_sof[k], cap_ar[k], cap_ai[k], cap_br[k], cap_bi[k]},
              {tbl[i].sof, 32'(tbl[i].ar), 32'(tbl[i].ai), 32'(tbl[i].br), 32'(tbl[i].bi)});
      else
        check($sformatf("%s_k%0d_missing", nm, k), cap_ar.size(), k + 1);
    end
  endtask

  task automatic check_burst(input string nm, input int pairs, input int sofs);
    int n_sof = 0;
    foreach (cap_sof[i]) if (cap_sof[i]) n_sof++;
    check({nm, "_pairs"}, cap_ar.size(), pairs);
    check({nm, "_sofs"}, n_sof, sofs);
    check({nm, "_sof_edges"}, sof_edge.size(), sofs);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{0,   0,    0,   512,  -512,  1'b1};
    tbl[1] = '{1,   1,   -1,   513,  -513,  1'b0};
    tbl[2] = '{100, 100, -100, 612,  -612,  1'b0};
    tbl[3] = '{255, 255, -255, 767,  -767,  1'b0};
    tbl[4] = '{511, 511, -511, 1023, -1023, 1'b0};

    #12;
    check("reset_outputs", {o_valid_out, o_sof, o_data_a_real, o_data_a_imag, o_data_b_real, o_data_b_imag}, '0);
    repeat (3) @(posedge i_clk);
    #2 i_reset = 1'b1;

    // 1: single ramp frame, continuous valid
    clear_cap();
    send_ramp(0, 0, N);
    drain("t1");
    check_burst("t1", H, 1);
    if (sof_edge.size() > 0) check("t1_latency", sof_edge[0] - last_done_edge, 3);
    check_table("t1");

    // 2: three back-to-back frames
    clear_cap();
    for (int f = 0; f < 3; f++) send_ramp(f * 4096, 0, N);
    drain("t2");
    check_burst("t2", 3 * H, 3);
    if (sof_edge.size() == 3) begin
      check("t2_period01", sof_edge[1] - sof_edge[0], N);
      check("t2_period12", sof_edge[2] - sof_edge[1], N);
    end
    if (cap_ar.size() == 3 * H) begin
      check("t2_f1_first", cap_ar[H], 4096);
      check("t2_f2_first", cap_ar[2*H], 8192);
      check("t2_f2_last_b", cap_br[3*H-1], 8192 + N - 1);
    end

    // 3: ~50% random gaps in i_valid_in
    clear_cap();
    send_ramp(0, 50, N);
    drain("t3");
    check_burst("t3", H, 1);
    if (sof_edge.size() > 0) check("t3_latency", sof_edge[0] - last_done_edge, 3);
    check_table("t3");

    // 4: reset in the middle of a frame being written
    clear_cap();
    send_ramp(0, 0, 500);
    @(posedge i_clk); #2;
    i_reset = 1'b0; i_valid_in = 1'b0;
    repeat (2) @(posedge i_clk);
    #2 i_reset = 1'b1;
    send_ramp(0, 0, N);
    drain("t4");
    check_burst("t4", H, 1);
    if (sof_edge.size() > 0) check("t4_latency", sof_edge[0] - last_done_edge, 3);
    check_table("t4");

    // 5: reset while pair k=100 is on the output
    clear_cap();
    send_ramp(0, 0, N);
    idle(1);
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge i_clk); #1;
      if (cap_ar.size() >= 101) break;
    end
    check("t5_reached_k100", cap_ar.size() >= 101, 1);
    i_reset = 1'b0;
    #1;
    check("t5_async_clear", {o_valid_out, o_sof, o_data_a_real, o_data_a_imag, o_data_b_real, o_data_b_imag}, '0);
    repeat (2) @(posedge i_clk);
    #2 i_reset = 1'b1;
    idle(H);
    check("t5_truncated", cap_ar.size(), 101);
    clear_cap();
    send_ramp(0, 0, N);
    drain("t5");
    check_burst("t5", H, 1);
    check_table("t5");

    // 6: signed extremes with random filler
    clear_cap();
    for (int n = 0; n < N; n++) begin
      if (n == 0)      drive(1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
      else if (n == H) drive(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
      else             drive(1'b1, $urandom, $urandom);
    end
    drain("t6");
    check_burst("t6", H, 1);
    if (cap_ar.size() > 0)
      check("t6_extremes", {cap_ar[0], cap_ai[0], cap_br[0], cap_bi[0]},
            {32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000});

    check("err_sticky", dut.err_sticky, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
